seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised, runtime-programmable serial bit-pattern detector with a registered Moore-style output and a saturating match counter. It generalises the fixed-pattern 5-bit detectors: the pattern (up to MAX_LEN bits), its length and the overlap mode are loaded at run time, and input bits are qualified by a valid strobe. The block sits on the serial receive path and flags framing or sync words to downstream control logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- DEFAULT_PATTERN, 8'b0001_0011: pattern after reset, right-aligned, MAX_LEN bits.
- DEFAULT_LEN, 5: pattern length after reset (default pattern is 10011).
- DEFAULT_OVERLAP, 1: overlap mode after reset.
- LEN_W (derived, not overridable): $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cfg_load  in  1  single-cycle pulse; latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- din_valid  in  1  qualifies din.
- din  in  1  serial data bit.
- seq_detected  out  1  registered, one cycle per match.
- match_count  out  CNT_W  saturating count of matches since reset or the last legal load.
- cfg_err  out  1  one-cycle pulse on an illegal cfg_load.

## Operation
- Registers:
  - hist[MAX_LEN-1:0]: shift register, newest bit in [0].
  - fill[LEN_W-1:0]: count of valid history bits, capped at len.
  - Active pattern, len and overlap.
  - seq_detected, match_count, cfg_err.
- FSM derived from fill:
  - FILL (fill < len).
  - ARMED (fill == len).
  - Reset enters FILL with fill = 0.
- Accepted bit (din_valid=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], din}.
  - fill_n = min(fill+1, len).
  - match = (fill_n == len) && (hist_n[len-1:0] == pattern[len-1:0]). Bits above len are ignored.
- On match:
  - seq_detected <= 1.
  - match_count increments, saturating at 2^CNT_W-1.
  - overlap=1: fill stays at len (FSM stays ARMED).
  - overlap=0: fill <= 0 (FSM returns to FILL), so the next match needs len fresh bits.
- No match, or din_valid=0: seq_detected <= 0. With din_valid=0, hist and fill hold.
- Legal cfg_load (1 ≤ cfg_len ≤ MAX_LEN):
  - Latch the new pattern, len and overlap.
  - hist <= 0, fill <= 0, match_count <= 0, seq_detected <= 0.
- Illegal cfg_load (cfg_len == 0 or cfg_len > MAX_LEN):
  - Active config, hist, fill and match_count are unchanged.
  - cfg_err <= 1 for one cycle; seq_detected <= 0 that cycle.
- cfg_load together with din_valid: the load takes priority and the bit is discarded, for both legal and illegal loads.
- len == 1: every accepted bit equal to pattern[0] matches, including consecutive bits in either overlap mode.
- Reset values:
  - seq_detected = 0, match_count = 0, cfg_err = 0.
  - hist = 0, fill = 0.
  - Active config = DEFAULT_PATTERN, DEFAULT_LEN, DEFAULT_OVERLAP.

## Timing
- din is sampled at a rising edge. seq_detected is high for exactly the following cycle when that bit completes a match. Latency is 1 cycle.
- Back-to-back matches (overlap, or len=1) give seq_detected high on consecutive cycles; there is no forced gap.
- match_count updates on the same edge as seq_detected.
- cfg_err is registered: it is high for the cycle after the illegal load.
- A config loaded at edge N takes effect for bits sampled at edge N+1 and later.
- Asserting reset mid-pattern clears all state immediately; the partial match is lost.
- No combinational path from any input to any output.

## Structure
- Package seq_det_pkg holds:
  - The LEN_W computation function.
  - The default pattern, length and overlap constants.
  - The FILL/ARMED state encoding.
- Sub-module seq_sat_counter(CNT_W): provides clear, inc and a saturating count. It is reusable by other detectors.
- Everything else stays in seq_detect_param.

## Test plan
- Reset defaults, overlap=1, stream 1,0,0,1,1,0,0,1,1 → seq_detected pulses after bits 5 and 9; match_count = 2.
- Load 10011, len 5, overlap=0, same stream → single pulse after bit 5; match_count = 1.
- Load 111, len 3:
  - overlap=1, six 1s → pulses after bits 3, 4, 5, 6; count 4.
  - overlap=0, six 1s → pulses after bits 3 and 6; count 2.
- Default pattern with din_valid low on random cycles mid-pattern and din toggling while invalid → detection unaffected, pulse one cycle after the fifth valid bit.
- CNT_W=2, len 1, pattern 1, eight valid 1s → seq_detected high 8 consecutive cycles; match_count saturates at 3.
- Illegal loads and reset:
  - cfg_load with cfg_len=0, and again with cfg_len=MAX_LEN+1 → cfg_err pulses; old pattern still detected; count not cleared.
  - Reset asserted after 1,0,0,1 → all outputs 0; after release, a further 1 alone does not match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the runtime-programmable pattern detector.
// Also holds the length-width helper used by detector ports.
package seq_det_pkg;

  localparam logic [7:0] DEF_PATTERN = 8'b0001_0011;
  localparam int         DEF_LEN     = 5;
  localparam logic       DEF_OVERLAP = 1'b1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_t;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones until cleared or reset.
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with runtime pattern, length and overlap.
// Registered match pulse, saturating match count and config-error pulse.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN         = 8,
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int                 DEFAULT_LEN     = DEF_LEN,
  parameter logic               DEFAULT_OVERLAP = DEF_OVERLAP,
  localparam int                LEN_W           = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  output logic               seq_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  det_state_t         r_state;
  logic               r_seq_det;
  logic               r_cfg_err;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_cfg_ok;
  logic               w_accept;
  logic               w_match;
  logic               w_clr;

  always_comb begin
    w_hist_n = {r_hist[MAX_LEN-2:0], din};
    w_fill_n = r_len;
    unique case (r_state)
      ST_FILL:  w_fill_n = r_fill + LEN_W'(1);
      ST_ARMED: w_fill_n = r_len;
      default:  w_fill_n = r_len;
    endcase
  end

  // Only the low r_len bits of history take part in the compare
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_cfg_ok = (cfg_len != '0) &&
                    (cfg_len <= LEN_W'(MAX_LEN));
  assign w_accept = din_valid && !cfg_load;
  assign w_match  = w_accept && (w_fill_n == r_len) &&
                    (((w_hist_n ^ r_pattern) & w_mask) == '0);
  assign w_clr    = cfg_load && w_cfg_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern <= DEFAULT_PATTERN;
      r_len     <= LEN_W'(DEFAULT_LEN);
      r_overlap <= DEFAULT_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= ST_FILL;
      r_seq_det <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_seq_det <= 1'b0;
      r_cfg_err <= 1'b0;
      if (cfg_load) begin
        if (w_cfg_ok) begin
          r_pattern <= cfg_pattern;
          r_len     <= cfg_len;
          r_overlap <= cfg_overlap;
          r_hist    <= '0;
          r_fill    <= '0;
          r_state   <= ST_FILL;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end else if (din_valid) begin
        r_hist <= w_hist_n;
        if (w_match) begin
          r_seq_det <= 1'b1;
          if (r_overlap) begin
            r_fill  <= r_len;
            r_state <= ST_ARMED;
          end else begin
            r_fill  <= '0;
            r_state <= ST_FILL;
          end
        end else begin
          r_fill  <= w_fill_n;
          r_state <= (w_fill_n == r_len) ? ST_ARMED : ST_FILL;
        end
      end
    end
  end

  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_inc   (w_match),
    .o_count (match_count)
  );

  assign seq_detected = r_seq_det;
  assign cfg_err      = r_cfg_err;

endmodule
